// File: rtl/csa8_unadd_pkg.sv
// Shared types and default sizing for the csa8_unadd operand-recovery block.
package csa8_unadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int DIGIT_DEF = 2;
    localparam int NSTEPS    = WIDTH_DEF / DIGIT_DEF;
    localparam int CNT_W     = $clog2(NSTEPS + 1);

endpackage

// File: rtl/csa8_unadd_sub_digit.sv
// DIGIT-bit ripple-borrow subtractor: d = x - y - bin, bout = borrow out of the digit.
module sub_digit
    import csa8_unadd_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic br;

    // Borrow ripples from bit 0 upward, one full-subtractor cell per bit
    always_comb begin
        br = bin;
        d  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & (y[i] | br)) | (y[i] & br);
        end
        bout = br;
    end

endmodule

// File: rtl/csa8_unadd.sv
// Digit-serial inverse of the carry-select adder: recovers b = {cout,sum} - a - cin
// and flags results that no WIDTH-bit b could have produced.
module csa8_unadd
    import csa8_unadd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             err
);

    localparam int            STEPS = WIDTH / DIGIT;
    localparam int            CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] a_r;
    logic             cout_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_r;
    logic             err_r;
    logic [DIGIT-1:0] dig;
    logic             dig_bout;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub (
        .x    (sum_r[DIGIT-1:0]),
        .y    (a_r[DIGIT-1:0]),
        .bin  (borrow_r),
        .d    (dig),
        .bout (dig_bout)
    );

    // State register; reset aborts any request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: accept in IDLE, step through all digits, hold result until consumed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign b         = b_r;
    assign err       = err_r;

    // Datapath: capture operands on accept, then one digit per RUN cycle, LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r    <= '0;
            a_r      <= '0;
            cout_r   <= 1'b0;
            borrow_r <= 1'b0;
            cnt      <= '0;
            b_r      <= '0;
            err_r    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sum_r    <= sum;
            a_r      <= a;
            cout_r   <= cout;
            borrow_r <= cin;
            cnt      <= '0;
        end else if (state == RUN) begin
            // Difference digits enter at the top so the LSB digit lands at bit 0 last
            b_r      <= {dig, b_r[WIDTH-1:DIGIT]};
            sum_r    <= sum_r >> DIGIT;
            a_r      <= a_r >> DIGIT;
            borrow_r <= dig_bout;
            cnt      <= cnt + CW'(1);
            // A carry-out not cancelled by a final borrow (or vice versa) means no valid b
            if (cnt == LAST) err_r <= cout_r ^ dig_bout;
        end
    end

endmodule

// File: tb/tb_csa8_unadd.sv
// Directed bench for csa8_unadd: latency, error flags, backpressure, reset abort, throughput.
module tb_csa8_unadd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] sum = '0;
    logic       cout = 1'b0;
    logic [7:0] a = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] b;
    logic       err;

    int checks = 0;
    int failures = 0;

    csa8_unadd dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .a         (a),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge right after the accept edge
    task automatic start_req(input logic [8:0] res, input logic [7:0] av, input logic cv);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        {cout, sum} = res;
        a = av;
        cin = cv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_run", in_ready, 0);
        chk("out_valid_run", out_valid, 0);
        // Inputs must not matter after the accept edge
        sum = ~sum;
        a = ~a;
        cin = ~cin;
        cout = ~cout;
    endtask

    // Called 'done' negedges after the accept edge's negedge; result must appear after edge k+4
    task automatic wait_done(input int done, input string tag, input logic [7:0] eb, input logic ee);
        repeat (3 - done) @(negedge clk);
        chk({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_b"}, b, eb);
        chk({tag, "_err"}, err, ee);
    endtask

    task automatic release_res();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released_valid", out_valid, 0);
        chk("released_ready", in_ready, 1);
    endtask

    logic [8:0] bb_res [2];
    logic [7:0] bb_a   [2];
    logic       bb_cin [2];
    logic [7:0] bb_b   [2];

    initial begin
        int acc[$];
        int nres;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_b", b, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Plain subtraction
        start_req(9'h0E3, 8'h01, 1'b0);
        wait_done(0, "t1", 8'hE2, 1'b0);
        release_res();

        // cout=1 cancelled by a final borrow
        start_req(9'h174, 8'hC1, 1'b1);
        wait_done(0, "t2", 8'hB2, 1'b0);
        release_res();

        // Negative b, with in_valid pulsed during RUN and backpressure in DONE
        start_req(9'h000, 8'h01, 1'b0);
        in_valid = 1'b1;
        sum = 8'h55;
        a = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(1, "t3", 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_b", b, 8'hFF);
            chk("bp_err", err, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        release_res();

        // Overflow: cout=1 with no borrow
        start_req(9'h1FF, 8'h00, 1'b0);
        wait_done(0, "t4", 8'hFF, 1'b1);
        release_res();

        // Reset during RUN aborts at once
        start_req(9'h174, 8'hC1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_b", b, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        start_req(9'h0E3, 8'h01, 1'b0);
        wait_done(0, "t5", 8'hE2, 1'b0);
        release_res();

        // Back-to-back with out_ready held high
        bb_res[0] = 9'h0EC; bb_a[0] = 8'hB1; bb_cin[0] = 1'b1; bb_b[0] = 8'h3A;
        bb_res[1] = 9'h020; bb_a[1] = 8'h1D; bb_cin[1] = 1'b1; bb_b[1] = 8'h02;
        nres = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("bb_b", b, bb_b[nres % 2]);
                chk("bb_err", err, 0);
                nres++;
            end
            if (in_ready) begin
                {cout, sum} = bb_res[acc.size() % 2];
                a = bb_a[acc.size() % 2];
                cin = bb_cin[acc.size() % 2];
                in_valid = 1'b1;
                acc.push_back(c);
            end
        end
        in_valid = 1'b0;
        chk("bb_results", nres >= 2, 1);
        chk("bb_accepts", acc.size() >= 3, 1);
        if (acc.size() >= 3) begin
            chk("bb_gap01", acc[1] - acc[0], 6);
            chk("bb_gap12", acc[2] - acc[1], 6);
        end
        repeat (8) @(negedge clk);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
